// File: rtl/fp_pkg.sv
// Shared FP32 constants, accumulator state encoding and classification helpers
// used by the accumulator stage and its adder.
package fp_pkg;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE      = 32'h3F80_0000;
  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  function automatic logic is_nan(input logic [31:0] fp);
    return (fp[30:23] == FP_EXP_MAX) && (fp[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] fp);
    return (fp[30:23] == FP_EXP_MAX) && (fp[22:0] == 23'd0);
  endfunction

endpackage

// File: rtl/Add_FP.sv
// Combinational FP32 adder: round-to-nearest-even, gradual underflow,
// sticky NaN/Inf; inf + -inf yields a quiet NaN signed like operand a on ties.
module Add_FP
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic [31:0] big_s;
  logic [30:0] small_s;
  logic [7:0]  e_big_s, e_small_s, d_s, sh_s;
  logic [23:0] m_big_s, m_small_s;
  logic [49:0] align_s;
  logic [26:0] small27_s, norm_s;
  logic [27:0] raw_s;
  logic [4:0]  lz_s;
  logic [9:0]  exp_s;
  logic [24:0] rnd_s;
  logic        round_up_s;
  logic [22:0] frac_s;

  // Align, add/subtract, normalise and round the magnitude path.
  always_comb begin
    if (a[30:0] >= b[30:0]) begin
      big_s   = a;
      small_s = b[30:0];
    end else begin
      big_s   = b;
      small_s = a[30:0];
    end
    e_big_s   = (big_s[30:23] == 8'd0) ? 8'd1 : big_s[30:23];
    e_small_s = (small_s[30:23] == 8'd0) ? 8'd1 : small_s[30:23];
    m_big_s   = {(big_s[30:23] != 8'd0), big_s[22:0]};
    m_small_s = {(small_s[30:23] != 8'd0), small_s[22:0]};
    d_s = e_big_s - e_small_s;
    if (d_s > 8'd27) begin
      d_s = 8'd27;
    end else begin
      d_s = d_s;
    end
    // Guard/round bits land in [25:23]; everything below folds into sticky.
    align_s   = {m_small_s, 26'd0} >> d_s;
    small27_s = {align_s[49:24], align_s[23] | (|align_s[22:0])};
    if (a[31] ^ b[31]) begin
      raw_s = {1'b0, m_big_s, 3'b000} - {1'b0, small27_s};
    end else begin
      raw_s = {1'b0, m_big_s, 3'b000} + {1'b0, small27_s};
    end
    lz_s = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (raw_s[i]) lz_s = 5'(26 - i);
    end
    sh_s = 8'd0;
    if (raw_s[27]) begin
      norm_s = {raw_s[27:2], raw_s[1] | raw_s[0]};
      exp_s  = {2'b00, e_big_s} + 10'd1;
    end else begin
      // Never shift below the minimum exponent; the result stays subnormal.
      if ({3'b000, lz_s} >= e_big_s) begin
        sh_s = e_big_s - 8'd1;
      end else begin
        sh_s = {3'b000, lz_s};
      end
      norm_s = raw_s[26:0] << sh_s;
      exp_s  = {2'b00, e_big_s} - {2'b00, sh_s};
      if (!norm_s[26]) begin
        exp_s = 10'd0;
      end else begin
        exp_s = exp_s;
      end
    end
    round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    rnd_s      = {1'b0, norm_s[26:3]} + {24'd0, round_up_s};
    if (rnd_s[24]) begin
      exp_s  = exp_s + 10'd1;
      frac_s = rnd_s[23:1];
    end else begin
      if ((exp_s == 10'd0) && rnd_s[23]) begin
        exp_s = 10'd1;
      end else begin
        exp_s = exp_s;
      end
      frac_s = rnd_s[22:0];
    end
  end

  // Special-value priority ahead of the finite result.
  always_comb begin
    if (is_nan(a)) begin
      sum = a | 32'h0040_0000;
    end else if (is_nan(b)) begin
      sum = b | 32'h0040_0000;
    end else if (is_inf(a) && is_inf(b) && (a[31] != b[31])) begin
      sum = {big_s[31], 31'h7FC0_0000};
    end else if (is_inf(a)) begin
      sum = a;
    end else if (is_inf(b)) begin
      sum = b;
    end else if (raw_s == 28'd0) begin
      sum = {a[31] & b[31], 31'd0};
    end else if (exp_s >= 10'd255) begin
      sum = {big_s[31], FP_EXP_MAX, 23'd0};
    end else begin
      sum = {big_s[31], exp_s[7:0], frac_s};
    end
  end

endmodule

// File: rtl/fp_accum_stage.sv
// Bias-preloaded FP32 accumulator: one term per clock through Add_FP, optional
// ReLU, result held under valid/ready until the next stage takes it.
module fp_accum_stage
  import fp_pkg::*;
#(
  parameter int MAX_TERMS = 4608,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1),
  parameter bit RELU      = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [31:0]      bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_TERMS);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  acc_state_t       state_r, state_nxt_s;
  logic [31:0]      acc_r, sum_s;
  logic [CNT_W-1:0] cnt_r, len_q_r, len_clamp_s;
  logic             take_s, last_s, relu_zero_s;

  Add_FP u_add (
    .a   (acc_r),
    .b   (in_data),
    .sum (sum_s)
  );

  assign len_clamp_s = (len > MAX_LEN) ? MAX_LEN : len;
  assign take_s      = (state_r == ACCUM) && in_valid;
  assign last_s      = take_s && (cnt_r == (len_q_r - CNT_ONE));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = (len == CNT_ZERO) ? DONE : ACCUM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Accumulator, term counter and captured run length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= FP_POS_ZERO;
      cnt_r   <= CNT_ZERO;
      len_q_r <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r   <= bias;
            len_q_r <= len_clamp_s;
            cnt_r   <= CNT_ZERO;
          end
        end
        ACCUM: begin
          if (take_s) begin
            acc_r <= sum_s;
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign relu_zero_s = RELU && acc_r[31] && !is_nan(acc_r);

  // Outputs decode only from registered state and accumulator.
  always_comb begin
    in_ready  = (state_r == ACCUM);
    out_valid = (state_r == DONE);
    busy      = (state_r != IDLE);
    if ((state_r == DONE) && !relu_zero_s) begin
      out_data = acc_r;
    end else begin
      out_data = FP_POS_ZERO;
    end
  end

endmodule

// File: doc/fp_accum_stage.md
Name: fp_accum_stage

Overview:
Sequential FP32 accumulator that consumes the product stream of a convolution window and reduces it to one sum. It sits directly downstream of the multiplier array and wraps the existing combinational Add_FP adder in a registered feedback loop. It is preloaded with a bias, accumulates a run-time number of terms at one term per cycle, and applies an optional ReLU. It holds the result under a valid/ready handshake until the next layer stage accepts it.

Parameters:
MAX_TERMS, 4608, largest accepted term count (3x3x512 VGG16 window).
CNT_W, $clog2(MAX_TERMS+1), width of the length port and the term counter.
RELU, 0, 1 forces negative non-NaN results to +0 on out_data.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse that starts a run; honoured only in IDLE.
len  in  CNT_W  number of terms for the run; sampled on start.
bias  in  32  FP32 initial accumulator value; sampled on start.
in_valid  in  1  product term valid.
in_ready  out  1  stage accepts a term this cycle.
in_data  in  32  FP32 product term.
out_valid  out  1  result available.
out_ready  in  1  downstream accepts the result.
out_data  out  32  FP32 result, post-ReLU when RELU=1.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=32'h0, cnt=0, len_q=0. Outputs in_ready=0, out_valid=0, out_data=32'h0, busy=0.
- States are IDLE, ACCUM and DONE. All outputs are decoded from registered state, with no combinational path from inputs to outputs.
- IDLE:
  - in_ready=0.
  - On start: acc<=bias, len_q<=len, cnt<=0.
  - If len==0, go to DONE; otherwise go to ACCUM.
  - len>MAX_TERMS is clamped to MAX_TERMS.
- ACCUM:
  - in_ready=1.
  - On a handshake (in_valid & in_ready): acc<=Add_FP(acc,in_data) and cnt<=cnt+1. The new acc is visible the next cycle, so the sustained rate is one term per clock.
  - A handshake with cnt==len_q-1 moves the FSM to DONE.
  - Cycles with in_valid=0 leave acc and cnt unchanged.
  - start is ignored.
- DONE:
  - out_valid=1, in_ready=0.
  - out_data=acc, or 32'h0 when RELU=1, acc[31]=1 and acc is not NaN (exp!=8'hFF or frac==0). -0 also maps to +0.
  - out_data is stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE. A start in that same cycle is ignored; start must be reissued in IDLE.
- Latency:
  - start to first in_ready: 1 cycle.
  - Last term handshake to out_valid: 1 cycle.
  - len=0: out_valid 1 cycle after start.
- Arithmetic: rounding and special-value rules are entirely those of Add_FP.
  - NaN and Inf are sticky: inf + -inf gives 0x7FC00000 or 0xFFC00000, with the sign of the larger-magnitude operand.
  - The block adds no extra saturation.
- Reset asserted mid-run aborts the run, returns to the reset values and drops any partial sum.
- Counter cnt never exceeds len_q and never wraps.

Decomposition:
- Shared package fp_pkg:
  - constants FP_POS_ZERO=32'h00000000, FP_ONE=32'h3F800000, FP_EXP_MAX=8'hFF;
  - accumulator state enum {IDLE, ACCUM, DONE};
  - function is_nan(fp).
- One sub-module: the existing Add_FP, instantiated once as u_add with operands (acc, in_data).
- The FSM, counter and ReLU are local to fp_accum_stage.

Test Plan:
- Basic sum: bias=0x3F800000 (1.0), len=3, terms 0x3F800000, 0x40000000, 0x3F000000 back-to-back -> out_valid 1 cycle after the 3rd handshake, out_data=0x40900000 (4.5), busy falls after out_ready.
- Bubbles and backpressure: same data with in_valid low for 2 cycles between terms, and out_ready held low 5 cycles -> identical 0x40900000, held stable, single transfer, in_ready=0 throughout DONE.
- Zero length: start with len=0, bias=0x40400000 -> out_valid next cycle with out_data=0x40400000; no term is accepted.
- ReLU: RELU=1, bias=0x00000000, len=1, term 0xC0000000 (-2.0) -> out_data=0x00000000. Same run with RELU=0 -> 0xC0000000.
- Specials: bias=0x7F800000 (+inf), len=2, terms 0xFF800000, 0x3F800000 -> out_data=0x7FC00000, and RELU=1 does not zero it.
- Reset and ignored start: rst_n low after 2 of 4 terms -> all outputs 0 immediately (asynchronously). A new run then gives a correct sum with no residue. A start pulse during ACCUM/DONE has no effect.
